// File: rtl/spatial_encoder_sram_multimod_pkg.sv
// rtl/spatial_encoder_sram_multimod_pkg.sv - shared types and sizing helpers for the spatial encoder
package spatial_encoder_sram_multimod_pkg;

  localparam int HV_DIM_DEF = 2000;
  localparam int N_MOD = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_MAJ,
    S_OUT
  } state_t;

  // Width never drops below 1 so single-channel modalities still get a real counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spatial_encoder_sram_multimod_if.sv
// rtl/spatial_encoder_sram_multimod_if.sv - sample, SRAM and result signals grouped per modality index
interface spatial_encoder_sram_multimod_if
  import spatial_encoder_sram_multimod_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEF,
  parameter int CH_W   = 8,
  parameter int N_CH   = 214,
  parameter int AW     = 7
);
  logic                             valid_in;
  logic                             ready_out;
  logic [CH_W*N_CH-1:0]             channels;
  logic [N_MOD-1:0]                 sram_req;
  logic [N_MOD-1:0][AW-1:0]         sram_addr;
  logic [N_MOD-1:0]                 sram_valid;
  logic [N_MOD-1:0][HV_DIM-1:0]     im;
  logic [N_MOD-1:0][HV_DIM-1:0]     proj_neg;
  logic [N_MOD-1:0][HV_DIM-1:0]     proj_pos;
  logic                             valid_out;
  logic                             ready_in;
  logic [N_MOD-1:0][HV_DIM-1:0]     hv;
  logic [HV_DIM-1:0]                hv_fused;

  modport master (
    output valid_in, channels, sram_valid, im, proj_neg, proj_pos, ready_in,
    input  ready_out, sram_req, sram_addr, valid_out, hv, hv_fused
  );

  modport slave (
    input  valid_in, channels, sram_valid, im, proj_neg, proj_pos, ready_in,
    output ready_out, sram_req, sram_addr, valid_out, hv, hv_fused
  );
endinterface

// File: rtl/spatial_encoder_sram_multimod_bundler.sv
// rtl/spatial_encoder_sram_multimod_bundler.sv - per-modality SRAM walker, sign binding and majority bundling
module spatial_encoder_sram_multimod_bundler
  import spatial_encoder_sram_multimod_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEF,
  parameter int CH_W   = 8,
  parameter int CH     = 2,
  parameter int AW     = 1,
  parameter int CW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 active,
  input  logic [CH_W*CH-1:0]   features,
  input  logic                 sram_valid,
  input  logic [HV_DIM-1:0]    im,
  input  logic [HV_DIM-1:0]    proj_neg,
  input  logic [HV_DIM-1:0]    proj_pos,
  output logic                 sram_req,
  output logic [AW-1:0]        sram_addr,
  output logic                 done_next,
  output logic [HV_DIM-1:0]    maj
);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     n_used;
  logic              done;
  logic [HV_DIM-1:0] tie;
  logic [CW-1:0]     bit_cnt [HV_DIM];
  logic [CH_W-1:0]   f;
  logic [HV_DIM-1:0] bound;
  logic              consume;
  logic              last;

  // Local channel 0 sits at the MSBs of the feature slice.
  always_comb begin
    f = '0;
    for (int i = 0; i < CH; i++) begin
      if (CW'(i) == cnt) f = features[CH_W*(CH-1-i) +: CH_W];
    end
  end

  assign bound     = im ^ (f[CH_W-1] ? proj_neg : proj_pos);
  assign sram_req  = active & ~done;
  assign sram_addr = AW'(cnt);
  assign consume   = sram_req & sram_valid;
  assign last      = (cnt == CW'(CH-1));
  assign done_next = done | (consume & last);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt    <= '0;
      n_used <= '0;
      done   <= 1'b0;
      tie    <= '0;
      for (int b = 0; b < HV_DIM; b++) bit_cnt[b] <= '0;
    end else if (consume) begin
      cnt  <= cnt + CW'(1);
      done <= last;
      if (f != '0) begin
        n_used <= n_used + CW'(1);
        if (n_used <= CW'(1)) tie <= tie ^ bound;
        for (int b = 0; b < HV_DIM; b++) bit_cnt[b] <= bit_cnt[b] + CW'(bound[b]);
      end
    end
  end

  // Exact halves fall back to the tie vector built from the first two contributors.
  always_comb begin
    maj = '0;
    for (int b = 0; b < HV_DIM; b++) begin
      maj[b] = ({bit_cnt[b], 1'b0} > {1'b0, n_used}) |
               (({bit_cnt[b], 1'b0} == {1'b0, n_used}) & tie[b]);
    end
  end

endmodule

// File: rtl/spatial_encoder_sram_multimod.sv
// rtl/spatial_encoder_sram_multimod.sv - sample capture, modality sequencing FSM, fusion and output registers
module spatial_encoder_sram_multimod
  import spatial_encoder_sram_multimod_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEF,
  parameter int CH_W   = 8,
  parameter int CH_M0  = 32,
  parameter int CH_M1  = 77,
  parameter int CH_M2  = 105,
  parameter int FUSE   = 1
) (
  input  logic clk,
  input  logic rst,
  spatial_encoder_sram_multimod_if.slave bus
);

  localparam int N_CH   = CH_M0 + CH_M1 + CH_M2;
  localparam int MAX_CH = max3(CH_M0, CH_M1, CH_M2);
  localparam int AW     = clog2_min1(MAX_CH);
  localparam int CW     = clog2_min1(MAX_CH + 1);

  state_t                       state;
  logic [CH_W*N_CH-1:0]         ch_reg;
  logic [N_MOD-1:0]             done_next;
  logic [N_MOD-1:0][HV_DIM-1:0] maj;
  logic                         start;
  logic                         active;

  assign start         = (state == S_IDLE) & bus.valid_in;
  assign active        = (state == S_ACCUM);
  assign bus.ready_out = (state == S_IDLE);

  for (genvar m = 0; m < N_MOD; m++) begin : g_mod
    localparam int CH   = (m == 0) ? CH_M0 : (m == 1) ? CH_M1 : CH_M2;
    localparam int BASE = (m == 0) ? 0 : (m == 1) ? CH_M0 : CH_M0 + CH_M1;
    if (CH > 0) begin : g_on
      spatial_encoder_sram_multimod_bundler #(
        .HV_DIM(HV_DIM), .CH_W(CH_W), .CH(CH), .AW(AW), .CW(CW)
      ) u_bundler (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .active    (active),
        .features  (ch_reg[CH_W*(N_CH-BASE)-1 -: CH_W*CH]),
        .sram_valid(bus.sram_valid[m]),
        .im        (bus.im[m]),
        .proj_neg  (bus.proj_neg[m]),
        .proj_pos  (bus.proj_pos[m]),
        .sram_req  (bus.sram_req[m]),
        .sram_addr (bus.sram_addr[m]),
        .done_next (done_next[m]),
        .maj       (maj[m])
      );
    end else begin : g_off
      assign bus.sram_req[m]  = 1'b0;
      assign bus.sram_addr[m] = '0;
      assign done_next[m]     = 1'b1;
      assign maj[m]           = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ch_reg        <= '0;
      bus.valid_out <= 1'b0;
      bus.hv        <= '0;
      bus.hv_fused  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.valid_in) begin
          ch_reg <= bus.channels;
          state  <= S_ACCUM;
        end
        S_ACCUM: if (&done_next) state <= S_MAJ;
        S_MAJ: begin
          bus.hv        <= maj;
          bus.hv_fused  <= (FUSE != 0) ? ((maj[0] & maj[1]) | (maj[0] & maj[2]) | (maj[1] & maj[2])) : '0;
          bus.valid_out <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: if (bus.ready_in) begin
          bus.valid_out <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spatial_encoder_sram_multimod.sv
// tb/tb_spatial_encoder_sram_multimod.sv - directed checks of a 2/3/0-channel, 8-bit encoder instance
module tb_spatial_encoder_sram_multimod;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   lat;

  always #5 clk = ~clk;

  spatial_encoder_sram_multimod_if #(.HV_DIM(8), .CH_W(8), .N_CH(5), .AW(2)) bus ();

  spatial_encoder_sram_multimod #(
    .HV_DIM(8), .CH_W(8), .CH_M0(2), .CH_M1(3), .CH_M2(0), .FUSE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [7:0] im, input logic [7:0] pn, input logic [7:0] pp);
    bus.im       = {3{im}};
    bus.proj_neg = {3{pn}};
    bus.proj_pos = {3{pp}};
  endtask

  task automatic run(input logic [39:0] ch, output int l);
    @(negedge clk);
    bus.channels = ch;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b0;
    l = 0;
    do begin
      @(posedge clk);
      l++;
      @(negedge clk);
      bus.valid_in = 1'b0;
    end while (!bus.valid_out && l < 60);
  endtask

  task automatic handshake;
    bus.ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b0;
    check("hs_idle", 64'({bus.valid_out, bus.ready_out}), 64'b01);
  endtask

  task automatic check_res(input string tag, input logic [7:0] h0, input logic [7:0] h1,
                           input logic [7:0] fu);
    check({tag, "_hv0"}, 64'(bus.hv[0]), 64'(h0));
    check({tag, "_hv1"}, 64'(bus.hv[1]), 64'(h1));
    check({tag, "_hv2"}, 64'(bus.hv[2]), 64'h0);
    check({tag, "_fused"}, 64'(bus.hv_fused), 64'(fu));
  endtask

  initial begin
    bus.valid_in   = 1'b0;
    bus.ready_in   = 1'b0;
    bus.channels   = '0;
    bus.sram_valid = 3'b111;
    set_mem(8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_valid", 64'({bus.ready_out, bus.valid_out}), 64'b10);
    check("rst_hv", 64'({bus.hv, bus.hv_fused}), 64'h0);
    check("rst_req", 64'(bus.sram_req), 64'h0);
    rst = 1'b0;

    // Basic sample: M0=(+1,+1), M1=(+1,-1,+1)
    set_mem(8'h00, 8'h0F, 8'hF0);
    run(40'h01_01_01_FF_01, lat);
    check("t1_latency", 64'(lat), 64'd5);
    check_res("t1", 8'hF0, 8'hF0, 8'hF0);
    handshake();

    // Even count with tie vector FF
    set_mem(8'h00, 8'h00, 8'hFF);
    run(40'h01_FF_01_01_01, lat);
    check_res("t2", 8'hFF, 8'hFF, 8'hFF);
    handshake();
    set_mem(8'h00, 8'h0F, 8'hF0);
    run(40'hFF_01_01_01_01, lat);
    check_res("t2b", 8'hFF, 8'hF0, 8'hF0);
    handshake();

    // Zero features skipped; single -5 gives IM^ProjNeg
    set_mem(8'h3C, 8'h5A, 8'hA5);
    run(40'h00_00_01_FF_01, lat);
    check_res("t3a", 8'h00, 8'h99, 8'h00);
    handshake();
    run(40'h00_FB_FB_FB_00, lat);
    check_res("t3b", 8'h66, 8'h66, 8'h66);
    handshake();

    // M1 stalls 10 cycles after its first channel; M0 keeps going
    set_mem(8'h00, 8'h0F, 8'hF0);
    @(negedge clk);
    bus.channels = 40'h01_01_01_FF_01;
    bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("t4_req_start", 64'({bus.sram_req, bus.sram_addr[1], bus.sram_addr[0]}), 64'b011_00_00);
    @(posedge clk);
    @(negedge clk);
    bus.sram_valid[1] = 1'b0;
    check("t4_addr_adv", 64'({bus.sram_addr[1], bus.sram_addr[0]}), 64'b01_01);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t4_stalled", 64'({bus.sram_req, bus.sram_addr[1], bus.ready_out}), 64'b010_01_0);
    bus.sram_valid[1] = 1'b1;
    lat = 12;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.valid_out && lat < 80);
    check("t4_latency", 64'(lat), 64'd15);
    check_res("t4", 8'hF0, 8'hF0, 8'hF0);

    // Backpressure: outputs held and new samples ignored
    for (int i = 0; i < 20; i++) begin
      bus.channels = 40'h80_80_80_80_80;
      bus.valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_hold", 64'({bus.valid_out, bus.ready_out, bus.hv, bus.hv_fused}),
            64'({1'b1, 1'b0, 24'h00F0F0, 8'hF0}));
    end
    handshake();
    check("t5_after", 64'({bus.hv, bus.hv_fused}), 64'({24'h00F0F0, 8'hF0}));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_no_capture", 64'({bus.ready_out, bus.sram_req}), 64'b1_000);

    // Reset in the middle of accumulation
    @(negedge clk);
    bus.channels = 40'h01_01_01_FF_01;
    bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_ready_valid", 64'({bus.ready_out, bus.valid_out}), 64'b10);
    check("t6_rst_out", 64'({bus.hv, bus.hv_fused, bus.sram_req}), 64'h0);
    set_mem(8'h00, 8'h00, 8'hFF);
    run(40'h01_FF_01_01_01, lat);
    check("t6_latency", 64'(lat), 64'd5);
    check_res("t6", 8'hFF, 8'hFF, 8'hFF);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
